// File: rtl/store_to_fetch_queue.sv
// store_to_fetch_queue: DEPTH-entry valid/ready FIFO carrying store-stage packets back to fetch
module store_to_fetch_queue #(
    parameter int DATA_W         = 64,
    parameter int DEPTH          = 4,
    parameter int ALMOST_FULL_TH = DEPTH - 1,
    parameter bit BYPASS         = 1'b0,
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              send_valid,
    output logic              send_ready,
    input  logic [DATA_W-1:0] send_data,
    output logic              recv_valid,
    input  logic              recv_ready,
    output logic [DATA_W-1:0] recv_data,
    output logic [CW-1:0]     count,
    output logic              almost_full,
    output logic [CW-1:0]     high_water
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d, hw_q, hw_d;
    logic              full, empty, byp, push, pop;

    // Handshakes, optional empty-queue bypass, and next-state for pointers, count and high-water
    always_comb begin
        full        = count_q == CW'(DEPTH);
        empty       = count_q == '0;
        byp         = BYPASS && empty && send_valid && !flush && !reset;
        send_ready  = !full && !flush && !reset;
        recv_valid  = (!empty || byp) && !flush && !reset;
        recv_data   = byp ? send_data : mem_q[rd_ptr_q];
        push        = send_valid && send_ready && !(byp && recv_ready);
        pop         = !empty && recv_valid && recv_ready;
        mem_d       = mem_q;
        if (push) mem_d[wr_ptr_q] = send_data;
        wr_ptr_d    = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d    = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d     = flush ? '0 : count_q + CW'(push) - CW'(pop);
        hw_d        = count_d > hw_q ? count_d : hw_q;
        count       = count_q;
        high_water  = hw_q;
        almost_full = count_q >= CW'(ALMOST_FULL_TH);
    end

    // State registers; reset clears storage too so recv_data reads zero out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hw_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hw_q     <= hw_d;
        end
    end

    a_no_push_full:  assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (reset) !(pop && empty));
    a_depth_pow2:    assert property (@(posedge clk) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
endmodule

// File: tb/tb_store_to_fetch_queue.sv
// tb_store_to_fetch_queue: random + directed checking of both bypass variants against a queue model
module tb_store_to_fetch_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fl = 1'b0, sv = 1'b0, rr = 1'b0;
    logic [7:0] sd = 8'h00;
    logic       sr [2];
    logic       rv [2];
    logic       af [2];
    logic [7:0] rd [2];
    logic [2:0] cnt [2];
    logic [2:0] hw [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] mbuf [2][4];
    int         mn [2];
    int         mhw [2];
    logic       dpush [2];
    logic       dpop [2];
    logic       dfl;
    logic [7:0] dd;

    always #5 clk = ~clk;

    store_to_fetch_queue #(.DATA_W(8), .DEPTH(4), .BYPASS(1'b0)) u0 (
        .clk(clk), .reset(reset), .flush(fl), .send_valid(sv), .send_ready(sr[0]),
        .send_data(sd), .recv_valid(rv[0]), .recv_ready(rr), .recv_data(rd[0]),
        .count(cnt[0]), .almost_full(af[0]), .high_water(hw[0]));

    store_to_fetch_queue #(.DATA_W(8), .DEPTH(4), .BYPASS(1'b1)) u1 (
        .clk(clk), .reset(reset), .flush(fl), .send_valid(sv), .send_ready(sr[1]),
        .send_data(sd), .recv_valid(rv[1]), .recv_ready(rr), .recv_data(rd[1]),
        .count(cnt[1]), .almost_full(af[1]), .high_water(hw[1]));

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[u%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: expected outputs from queue contents and current inputs, plus this cycle's transfer decision
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int n;
            logic byp, e_sr, e_rv;
            if (reset) begin
                mn[k] = 0;
                mhw[k] = 0;
            end
            n    = mn[k];
            byp  = (k == 1) && n == 0 && sv && !fl && !reset;
            e_sr = !reset && !fl && n < 4;
            e_rv = !reset && !fl && (n != 0 || byp);
            chk("send_ready", k, int'(sr[k]), int'(e_sr));
            chk("recv_valid", k, int'(rv[k]), int'(e_rv));
            chk("count", k, int'(cnt[k]), n);
            chk("almost_full", k, int'(af[k]), int'(n >= 3));
            chk("high_water", k, int'(hw[k]), mhw[k]);
            if (e_rv) chk("recv_data", k, int'(rd[k]), int'(n != 0 ? mbuf[k][0] : sd));
            if (reset) chk("recv_data_rst", k, int'(rd[k]), 0);
            dpush[k] = sv && e_sr && !(byp && rr);
            dpop[k]  = e_rv && rr && n != 0;
        end
        dfl = fl;
        dd  = sd;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset || dfl) begin
                mn[k] = 0;
            end else begin
                if (dpop[k]) begin
                    for (int j = 0; j < 3; j++) mbuf[k][j] = mbuf[k][j+1];
                    mn[k]--;
                end
                if (dpush[k]) begin
                    mbuf[k][mn[k]] = dd;
                    mn[k]++;
                end
            end
            if (reset) mhw[k] = 0;
            else if (mn[k] > mhw[k]) mhw[k] = mn[k];
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        sv = v; sd = d; rr = r; fl = f;
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; mhw[k] = 0; dpush[k] = 0; dpop[k] = 0;
        end
        dfl = 0; dd = 0;
        #3;
        chk("rst_send_ready", 0, int'(sr[0]), 0);
        chk("rst_recv_valid", 0, int'(rv[0]), 0);
        #9 reset = 1'b0;
        // basic latency-1 push then pop
        step(1, 8'h11, 0, 0);
        chk("first_ready", 0, int'(sr[0]), 1);
        step(0, 8'h00, 1, 0);
        chk("t1_valid", 0, int'(rv[0]), 1);
        chk("t1_data", 0, int'(rd[0]), 8'h11);
        chk("t1_count", 0, int'(cnt[0]), 1);
        step(0, 8'h00, 0, 0);
        chk("t1_empty", 0, int'(rv[0]), 0);
        chk("t1_count0", 0, int'(cnt[0]), 0);
        // fill to full
        step(1, 8'd1, 0, 0);
        step(1, 8'd2, 0, 0);
        step(1, 8'd3, 0, 0);
        step(1, 8'd4, 0, 0);
        chk("t2_af", 0, int'(af[0]), 1);
        step(1, 8'd5, 0, 0);
        chk("t2_full_ready", 0, int'(sr[0]), 0);
        chk("t2_count", 0, int'(cnt[0]), 4);
        chk("t2_hw", 0, int'(hw[0]), 4);
        // full with simultaneous pop still refuses push
        step(1, 8'd5, 1, 0);
        chk("t3_head", 0, int'(rd[0]), 1);
        step(1, 8'd5, 0, 0);
        chk("t3_count", 0, int'(cnt[0]), 3);
        chk("t3_ready", 0, int'(sr[0]), 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1, 0);
            chk("t3_drain", 0, int'(rd[0]), i + 2);
        end
        // steady push+pop at count 2
        step(1, 8'h20, 0, 0);
        step(1, 8'h21, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h22 + i), 1, 0);
            chk("t4_count", 0, int'(cnt[0]), 2);
            chk("t4_order", 0, int'(rd[0]), 8'h20 + i);
        end
        // flush with a push offered
        step(1, 8'h40, 0, 0);
        step(1, 8'h77, 0, 1);
        chk("t5_count_pre", 0, int'(cnt[0]), 3);
        chk("t5_flush_valid", 0, int'(rv[0]), 0);
        step(0, 8'h00, 0, 0);
        chk("t5_count", 0, int'(cnt[0]), 0);
        chk("t5_hw", 0, int'(hw[0]), 4);
        // bypass pass-through and stored case
        step(1, 8'hAB, 1, 0);
        chk("t6_byp_valid", 1, int'(rv[1]), 1);
        chk("t6_byp_data", 1, int'(rd[1]), 8'hAB);
        step(0, 8'h00, 0, 0);
        chk("t6_byp_count", 1, int'(cnt[1]), 0);
        chk("t6_nobyp_count", 0, int'(cnt[0]), 1);
        step(1, 8'hCD, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("t6_stored", 1, int'(cnt[1]), 1);
        step(0, 8'h00, 0, 1);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        // async reset mid-fill
        step(0, 8'h00, 0, 1);
        step(1, 8'h55, 0, 0);
        step(1, 8'h56, 0, 0);
        step(0, 8'h00, 0, 0);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("ar_send_ready", k, int'(sr[k]), 0);
            chk("ar_recv_valid", k, int'(rv[k]), 0);
            chk("ar_recv_data", k, int'(rd[k]), 0);
            chk("ar_count", k, int'(cnt[k]), 0);
            chk("ar_hw", k, int'(hw[k]), 0);
            chk("ar_af", k, int'(af[k]), 0);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 100; i++)
            step(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
